// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, MEM_LATENCY-deep BRAM request tracker, DEPTH-entry queue.
// Request to valid_d takes MEM_LATENCY+1 cycles; credit is count+inflight < DEPTH. FETCH_QUEUE_PERF_EN adds perf counters.
module fetch_queue #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              MEM_LATENCY = 1,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     stall_d,
  output logic                     valid_d,
  output logic [31:0]              instr_d,
  output logic [XLEN-1:0]          pc_d,
  output logic [XLEN-1:0]          pc_plus4_d,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_kill_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 3;

  logic [XLEN-1:0]        r_fetch_pc;
  logic [MEM_LATENCY-1:0] r_trk_vld;
  logic [XLEN-1:0]        r_trk_pc [MEM_LATENCY];
  logic [31:0]            r_q_instr [DEPTH];
  logic [XLEN-1:0]        r_q_pc [DEPTH];
  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [CW-1:0]          r_count;

  logic [SW-1:0]          w_inflight;
  logic [SW-1:0]          w_used;
  logic                   w_push;
  logic                   w_pop;

  // Credit uses only registered state, so a pop this cycle frees a slot next cycle.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_trk_vld[i]);
    end
    w_used    = SW'(r_count) + w_inflight;
    imem_addr = redirect_valid ? redirect_pc : r_fetch_pc;
    imem_req  = !reset && (redirect_valid || (w_used < SW'(DEPTH)));
    w_push    = r_trk_vld[MEM_LATENCY-1] && !redirect_valid;
    valid_d   = (r_count != '0);
    w_pop     = valid_d && !stall_d && !redirect_valid;
  end

  always_comb begin
    instr_d    = '0;
    pc_d       = '0;
    pc_plus4_d = '0;
    if (valid_d) begin
      instr_d    = r_q_instr[r_head];
      pc_d       = r_q_pc[r_head];
      pc_plus4_d = r_q_pc[r_head] + XLEN'(4);
    end
  end

  assign count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (imem_req) begin
      r_fetch_pc <= imem_addr + XLEN'(4);
    end
  end

  // Slot 0 holds the request just issued; slot MEM_LATENCY-1 matches imem_rdata this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trk_vld <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_trk_pc[i] <= '0;
      end
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        r_trk_vld[i] <= r_trk_vld[i-1] && !redirect_valid;
        r_trk_pc[i]  <= r_trk_pc[i-1];
      end
      r_trk_vld[0] <= imem_req;
      r_trk_pc[0]  <= imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_tail] <= imem_rdata;
      r_q_pc[r_tail]    <= r_trk_pc[MEM_LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (imem_req)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid)    perf_kill_cnt  <= perf_kill_cnt + 32'(w_inflight);
      if (valid_d && stall_d) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the BRAM-based pipelined RV32 core. It replaces the single PCF register with a PC generator, a fixed-latency synchronous BRAM request tracker and a DEPTH-entry instruction queue. Decode stalls are absorbed in the queue, and redirects discard every in-flight fetch. It sits between the instruction BRAM and the IF/ID boundary, and its valid output replaces the FlushD bubble mechanism.

Parameters:
XLEN, 32, PC/address width.
DEPTH, 4, queue entries; power of two, 2..16.
MEM_LATENCY, 1, BRAM read latency in cycles; 1..4.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request issued this cycle
imem_addr  out  XLEN  byte address of request
imem_rdata  in  32  instruction word, valid exactly MEM_LATENCY cycles after its imem_req
redirect_valid  in  1  branch/jump taken in Execute (PCSrcE != 0)
redirect_pc  in  XLEN  target PC
stall_d  in  1  decode cannot accept (StallD)
valid_d  out  1  instr_d/pc_d hold a live instruction
instr_d  out  32  instruction at queue head
pc_d  out  XLEN  PC of instr_d
pc_plus4_d  out  XLEN  pc_d + 4, modulo 2^XLEN
count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (asynchronous):
  - fetch_pc = RESET_PC; queue empty; all in-flight slots invalid.
  - valid_d=0, imem_req=0, count=0; instr_d/pc_d/pc_plus4_d = 0.
- Address selection (combinational):
  - imem_addr = redirect_valid ? redirect_pc : fetch_pc.
- Credit:
  - inflight = number of valid slots in a MEM_LATENCY-deep tracker shift register.
  - imem_req = 1 when reset is low and (count_after_flush + inflight_after_flush) < DEPTH.
  - During a redirect both terms are 0, so imem_req is always 1.
  - A pop in the current cycle does not create credit until the next cycle; no combinational path from stall_d to imem_req.
- On an issued request: fetch_pc <= imem_addr + 4 (wraps at 2^XLEN). With no request, fetch_pc holds. Each tracker slot carries {valid, pc}.
- Response:
  - When the tracker tail slot is valid, imem_rdata and the slot pc are written into the queue at the tail.
  - They become visible on valid_d no earlier than the next cycle.
  - Latency from imem_req to valid_d = MEM_LATENCY+1 cycles.
- Pop: valid_d && !stall_d advances the head at the clock edge. Outputs hold stable while stall_d=1.
- Simultaneous push and pop: both occur; count unchanged. Overflow cannot occur by construction; assertion required.
- Redirect (highest priority), same cycle:
  - Queue is cleared (count=0 next cycle).
  - Every tracker slot is invalidated, including the response arriving this cycle.
  - Any pop is ignored.
  - New request to redirect_pc is issued.
  - valid_d is 0 next cycle.
  - First target instruction appears on valid_d MEM_LATENCY+1 cycles after the redirect.
- Back-to-back redirects: the latest wins. Earlier target fetches are killed like any other in-flight fetch.
- Empty queue: valid_d=0. instr_d shows a don't-care; the bench checks only when valid_d=1.
- valid_d=0 is treated by decode as a NOP bubble.
- Reset mid-operation: everything returns to reset values immediately. Responses in flight at reset are never enqueued.
- No misaligned-PC check; bits [1:0] of imem_addr are passed through.

Optional Feature:
FETCH_QUEUE_PERF_EN. When defined, three extra ports are added:
- perf_fetch_cnt: 32-bit, wrapping; counts cycles with imem_req=1.
- perf_kill_cnt: 32-bit, wrapping; counts tracker slots invalidated by redirect.
- perf_stall_cnt: 32-bit, wrapping; counts cycles with valid_d && stall_d.
All three reset to 0. When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, MEM_LATENCY=1, DEPTH=4, BRAM model with word = address, stall_d=0 -> imem_addr 0,4,8,... every cycle; first valid_d at cycle 2 with pc_d=0, instr_d=0; then one instruction per cycle, pc_plus4_d=pc_d+4.
- Hold stall_d=1 for 10 cycles from pc_d=0x8 -> outputs frozen at 0x8; count saturates at 4; imem_req drops once count+inflight=4; release resumes 0x8,0xC,... with no loss or duplication.
- redirect_valid=1, redirect_pc=0x100 while 2 entries are queued and 1 is in flight -> next cycle valid_d=0, count=0; pc_d=0x100 appears 2 cycles after the redirect; the killed response is never seen.
- MEM_LATENCY=3, redirect on consecutive cycles to 0x200 then 0x300 -> only 0x300,0x304,... reach valid_d; first at 4 cycles after the second redirect; perf_kill_cnt (macro on) counts the killed slots.
- Assert reset mid-stream with 3 entries queued and a stall active -> valid_d=0 and count=0 immediately; after release fetching restarts at RESET_PC.
- fetch_pc=0xFFFF_FFFC, XLEN=32 -> next imem_addr=0x0000_0000; pc_plus4_d for that entry = 0x0.
